// File: rtl/adder4_seq_ctrl_if.sv
// Requester-side bundle for the nibble-serial adder sequencer: start/op capture in, busy/done/result out.
// The master drives the request; the slave (sequencer) returns status and the held result.
interface adder4_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/adder4_seq_ctrl.sv
// Wide add done one nibble per cycle through an external combinational adder4; done pulses NIBBLES cycles after start.
// No backpressure: start is taken only in IDLE/DONE and dropped while busy; the result holds until the next completion.
module adder4_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    adder4_seq_ctrl_if.slave   req,
    output logic [3:0]         add_a_o,
    output logic [3:0]         add_b_o,
    output logic               add_cin_o,
    input  logic [3:0]         add_sum_i,
    input  logic               add_cout_i
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  shadow_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          busy_q;
    logic          done_q;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [W-1:0]  sum_d;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                nib_a = a_q[n*4 +: 4];
                nib_b = b_q[n*4 +: 4];
            end
        end
    end

    // The top nibble comes straight from the adder on the completing edge.
    always_comb begin
        sum_d          = shadow_q;
        sum_d[W-1 -: 4] = add_sum_i;
    end

    assign add_a_o   = (state_q == RUN) ? nib_a : 4'd0;
    assign add_b_o   = (state_q == RUN) ? nib_b : 4'd0;
    assign add_cin_o = (state_q == RUN) ? carry_q : 1'b0;

    assign req.busy = busy_q;
    assign req.done = done_q;
    assign req.sum  = sum_q;
    assign req.cout = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (req.start) begin
                        a_q     <= req.op_a;
                        b_q     <= req.op_b;
                        carry_q <= req.cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx_q == IW'(n)) begin
                            shadow_q[n*4 +: 4] <= add_sum_i;
                        end
                    end
                    carry_q <= add_cout_i;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= sum_d;
                        cout_q  <= add_cout_i;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
